// File: rtl/pet_needs_engine_pkg.sv
// Shared encodings, decay-field extraction and saturating level arithmetic for the pet needs engine.
// Level math runs in a 9-bit space, which leaves at least one guard bit for any LVL_W up to 8.
`ifndef PET_DECAY_FIELD
`define PET_DECAY_FIELD(vec, idx) vec[8*(idx) +: 8]
`endif

package pet_needs_engine_pkg;

    typedef enum logic [1:0] {
        NEED_OK    = 2'd0,
        NEED_CRIT  = 2'd1,
        NEED_EMPTY = 2'd2
    } needState_t;

    typedef enum logic {
        ALIVE = 1'b0,
        DEAD  = 1'b1
    } lifeState_t;

    localparam int ARITH_W = 9;

    // Simultaneous inc and dec cancel out; otherwise step once and clamp to [0, maxLvl].
    function automatic logic [ARITH_W-1:0] satStep(
        input logic [ARITH_W-1:0] lvl,
        input logic               inc,
        input logic               dec,
        input logic [ARITH_W-1:0] maxLvl
    );
        logic [ARITH_W-1:0] res;
        res = lvl;
        if (inc && !dec) begin
            res = (lvl >= maxLvl) ? maxLvl : lvl + 9'd1;
        end else if (dec && !inc) begin
            res = (lvl == '0) ? '0 : lvl - 9'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/need_channel.sv
// One need meter: care edge detect, decay timer, saturating level and OK/CRITICAL/EMPTY state.
// Events land on the edge that sees them (1-cycle latency); no backpressure, kill blanks and locks the meter.
module need_channel
    import pet_needs_engine_pkg::*;
#(
    parameter int LVL_W    = 3,
    parameter int LVL_MAX  = 5,
    parameter int CRIT_LVL = 2,
    parameter int DECAY    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             care,
    input  logic             kill,
    output logic [LVL_W-1:0] lvl,
    output logic             empty,
    output logic             crit
);

    localparam int                  DCNT_W    = (DECAY > 1) ? $clog2(DECAY) : 1;
    localparam logic [DCNT_W-1:0]   DCNT_LAST = DCNT_W'(DECAY - 1);
    localparam logic [ARITH_W-1:0]  MAX_A     = ARITH_W'(LVL_MAX);

    logic              careQ;
    logic [DCNT_W-1:0] decayCnt;
    logic [LVL_W-1:0]  level;
    logic              careRise;
    logic              decayHit;
    needState_t        state;

    assign careRise = care && !careQ;
    assign decayHit = tick && (decayCnt == DCNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            careQ    <= 1'b0;
            decayCnt <= '0;
            level    <= LVL_W'(LVL_MAX);
        end else begin
            careQ <= care;
            if (kill) begin
                decayCnt <= '0;
                level    <= '0;
            end else begin
                if (tick) begin
                    decayCnt <= decayHit ? '0 : decayCnt + DCNT_W'(1);
                end
                level <= LVL_W'(satStep(ARITH_W'(level), careRise, decayHit, MAX_A));
            end
        end
    end

    always_comb begin
        state = NEED_OK;
        if (level == '0) begin
            state = NEED_EMPTY;
        end else if (level <= LVL_W'(CRIT_LVL)) begin
            state = NEED_CRIT;
        end
    end

    assign lvl   = kill ? '0 : level;
    assign empty = (state == NEED_EMPTY);
    assign crit  = kill || (state != NEED_OK);

endmodule

// File: rtl/pet_needs_engine.sv
// Pet needs engine: shared tick prescaler, NUM_NEEDS decaying need meters, health penalty and ALIVE/DEAD FSM.
// Level updates visible one cycle after the event; no backpressure, inputs are sampled every cycle.
module pet_needs_engine
    import pet_needs_engine_pkg::*;
#(
    parameter int                     NUM_NEEDS            = 4,
    parameter int                     LVL_W                = 3,
    parameter int                     LVL_MAX              = 5,
    parameter int                     CRIT_LVL             = 2,
    parameter int                     CLK_PER_TICK         = 50000000,
    parameter logic [8*NUM_NEEDS-1:0] DECAY_VEC            = {8'd23, 8'd25, 8'd31, 8'd30},
    parameter int                     HEALTH_PENALTY_TICKS = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pause,
    input  logic [NUM_NEEDS-1:0]       care,
    input  logic                       heal,
    output logic [NUM_NEEDS*LVL_W-1:0] need_lvl,
    output logic [LVL_W-1:0]           health_lvl,
    output logic [NUM_NEEDS-1:0]       crit,
    output logic                       dead,
    output logic                       tick
);

    localparam int                 PS_W    = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(CLK_PER_TICK - 1);
    localparam int                 ACC_W   = $clog2(HEALTH_PENALTY_TICKS + 2);
    localparam logic [ARITH_W-1:0] MAX_A   = ARITH_W'(LVL_MAX);

    lifeState_t           life;
    lifeState_t           lifeNext;
    logic [PS_W-1:0]      psCnt;
    logic                 runPs;
    logic [ACC_W-1:0]     accCnt;
    logic [ACC_W-1:0]     accInc;
    logic [ACC_W-1:0]     accSum;
    logic [LVL_W-1:0]     health;
    logic                 healQ;
    logic                 healRise;
    logic                 penalty;
    logic                 anyEmpty;
    logic                 anyCrit;
    logic                 kill;
    logic [NUM_NEEDS-1:0] emptyVec;

    assign kill  = (life == DEAD);
    // A dead pet still keeps time, so pause only matters while alive.
    assign runPs = !pause || kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psCnt <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= runPs && (psCnt == PS_LAST);
            if (runPs) begin
                psCnt <= (psCnt == PS_LAST) ? '0 : psCnt + PS_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_NEEDS; g++) begin : gNeed
        need_channel #(
            .LVL_W    (LVL_W),
            .LVL_MAX  (LVL_MAX),
            .CRIT_LVL (CRIT_LVL),
            .DECAY    (int'(`PET_DECAY_FIELD(DECAY_VEC, g)))
        ) uNeed (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .care  (care[g]),
            .kill  (kill),
            .lvl   (need_lvl[g*LVL_W +: LVL_W]),
            .empty (emptyVec[g]),
            .crit  (crit[g])
        );
    end

    assign anyEmpty = |emptyVec;
    assign anyCrit  = |crit;
    assign accInc   = anyEmpty ? ACC_W'(2) : (anyCrit ? ACC_W'(1) : '0);
    assign accSum   = accCnt + accInc;
    assign penalty  = tick && anyCrit && (accSum >= ACC_W'(HEALTH_PENALTY_TICKS));
    assign healRise = heal && !healQ && !kill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            accCnt <= '0;
            health <= LVL_W'(LVL_MAX);
            healQ  <= 1'b0;
        end else begin
            healQ <= heal;
            if (!kill) begin
                if (tick) begin
                    accCnt <= (penalty || !anyCrit) ? '0 : accSum;
                end
                health <= LVL_W'(satStep(ARITH_W'(health), healRise, penalty, MAX_A));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            life <= ALIVE;
        end else begin
            life <= lifeNext;
        end
    end

    always_comb begin
        lifeNext = life;
        case (life)
            ALIVE: if (penalty && !healRise && (health == LVL_W'(1))) lifeNext = DEAD;
            DEAD:  lifeNext = DEAD;
            default: lifeNext = ALIVE;
        endcase
    end

    assign dead       = kill;
    assign health_lvl = kill ? '0 : health;

endmodule

// File: tb/tb_pet_needs_engine.sv
// Directed bench for pet_needs_engine: 4-clock tick, decay every 2 ticks, penalty threshold 4.
module tb_pet_needs_engine;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        pause = 1'b0;
    logic        heal  = 1'b0;
    logic [3:0]  care  = 4'h0;
    logic [11:0] need_lvl;
    logic [2:0]  health_lvl;
    logic [3:0]  crit;
    logic        dead;
    logic        tick;

    int assertCount = 0;
    int failCount   = 0;
    int n;
    int pulses;

    always #5 clk = ~clk;

    pet_needs_engine #(
        .NUM_NEEDS            (4),
        .LVL_W                (3),
        .LVL_MAX              (5),
        .CRIT_LVL             (2),
        .CLK_PER_TICK         (4),
        .DECAY_VEC            (32'h02020202),
        .HEALTH_PENALTY_TICKS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .care       (care),
        .heal       (heal),
        .need_lvl   (need_lvl),
        .health_lvl (health_lvl),
        .crit       (crit),
        .dead       (dead),
        .tick       (tick)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        assert (got === exp) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitTick(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!tick && cycles < 64);
    endtask

    initial begin
        cyc(3);
        check("rst_need", need_lvl, 12'hB6D);
        check("rst_health", health_lvl, 3'd5);
        check("rst_crit", crit, 4'h0);
        check("rst_dead", dead, 1'b0);
        check("rst_tick", tick, 1'b0);
        rst = 1'b1;

        waitTick(n);
        check("tick1_period", n, 4);
        waitTick(n);
        check("tick2_period", n, 4);
        check("need_before_decay", need_lvl, 12'hB6D);
        cyc(1);
        check("need_after_2ticks", need_lvl, 12'h924);
        check("tick_one_cycle", tick, 1'b0);

        // care[0] held for 20 clocks gives exactly one increment
        care = 4'b0001;
        cyc(1);
        check("care0_rise", need_lvl, 12'h925);
        cyc(6);
        check("care0_held", need_lvl, 12'h925);
        cyc(1);
        check("decay_e17", need_lvl, 12'h6DC);
        check("crit_e17", crit, 4'h0);
        cyc(8);
        check("decay_e25", need_lvl, 12'h493);
        check("crit_e25", crit, 4'hE);
        cyc(4);
        care = 4'b0000;
        check("health_e29", health_lvl, 3'd5);

        // care[1] rise coincides with the channel-1 decay
        cyc(3);
        care = 4'b0010;
        cyc(1);
        care = 4'b0000;
        check("care_vs_decay", need_lvl, 12'h252);
        check("crit_all", crit, 4'hF);
        cyc(7);
        check("need_e40", need_lvl, 12'h252);
        check("health_e40", health_lvl, 3'd5);
        cyc(1);
        check("decay_e41", need_lvl, 12'h009);
        check("health_first_drop", health_lvl, 3'd4);
        cyc(8);
        check("need_all_empty", need_lvl, 12'h000);
        check("health_empty_drop", health_lvl, 3'd3);
        check("alive_e49", dead, 1'b0);

        // heal rise on the same edge as a penalty cancels it
        cyc(7);
        heal = 1'b1;
        cyc(1);
        heal = 1'b0;
        check("heal_vs_penalty", health_lvl, 3'd3);
        cyc(8);
        check("health_e65", health_lvl, 3'd2);
        cyc(15);
        check("health_e80", health_lvl, 3'd1);
        check("alive_e80", dead, 1'b0);
        cyc(1);
        check("dead_flag", dead, 1'b1);
        check("dead_health", health_lvl, 3'd0);
        check("dead_need", need_lvl, 12'h000);
        check("dead_crit", crit, 4'hF);

        // inputs ignored while dead, prescaler keeps running through pause
        care  = 4'hF;
        heal  = 1'b1;
        pause = 1'b1;
        waitTick(n);
        check("dead_tick_period", n, 3);
        check("dead_need_hold", need_lvl, 12'h000);
        check("dead_health_hold", health_lvl, 3'd0);
        check("dead_stays", dead, 1'b1);
        care  = 4'h0;
        heal  = 1'b0;
        pause = 1'b0;

        // asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        check("async_need", need_lvl, 12'hB6D);
        check("async_health", health_lvl, 3'd5);
        check("async_dead", dead, 1'b0);
        check("async_tick", tick, 1'b0);
        check("async_crit", crit, 4'h0);
        cyc(2);
        rst = 1'b1;

        // saturation at LVL_MAX for both care and heal
        care = 4'b0100;
        heal = 1'b1;
        cyc(1);
        care = 4'b0000;
        heal = 1'b0;
        check("care_sat", need_lvl, 12'hB6D);
        check("heal_sat", health_lvl, 3'd5);

        // pause freezes the prescaler at its current count
        cyc(1);
        pause  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (tick) pulses++;
        end
        check("pause_no_tick", pulses, 0);
        check("pause_need", need_lvl, 12'hB6D);
        pause = 1'b0;
        waitTick(n);
        check("resume_from_held", n, 2);
        cyc(1);
        check("resume_tick_pulse", tick, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pet_needs_engine.md
Name: pet_needs_engine

Overview:
- Parametrised successor to the fixed five-meter pet status FSM.
- Tracks NUM_NEEDS independent need meters (food, sleep, fun, happy, ...) plus one health meter. Each meter saturates at LVL_MAX and is driven from a shared tick prescaler.
- Each need channel has its own decay period. Health is penalised while any need is critical, and the block enters a terminal DEAD state.
- Sits between the debounced user-input drivers and the display/LED drivers.

Parameters:
NUM_NEEDS, 4, number of need channels (1..8)
LVL_W, 3, width of every level output
LVL_MAX, 5, reset/saturation level (must be < 2**LVL_W)
CRIT_LVL, 2, need level at or below which the channel is critical
CLK_PER_TICK, 50000000, clocks per tick (bench uses small values)
DECAY_VEC, {8'd23,8'd25,8'd31,8'd30}, per-channel decay period in ticks; channel i uses bits [8i+7:8i]; each field must be ≥1
HEALTH_PENALTY_TICKS, 10, penalty accumulator threshold; must be ≥2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
pause  in  1  1 = freeze prescaler; no tick generated
care  in  NUM_NEEDS  per-channel care request (level, edge-detected inside)
heal  in  1  heal request (level, edge-detected inside)
need_lvl  out  NUM_NEEDS*LVL_W  channel i at [i*LVL_W +: LVL_W]
health_lvl  out  LVL_W  health meter
crit  out  NUM_NEEDS  1 = channel level ≤ CRIT_LVL
dead  out  1  terminal state flag
tick  out  1  one-cycle pulse on each prescaler wrap

Behaviour:
- Reset (rst=0, asynchronous, any time): need_lvl all LVL_MAX; health_lvl=LVL_MAX; crit=0; dead=0; tick=0. All counters=0. Edge-detect registers=0.
- Prescaler:
  - Counts 0..CLK_PER_TICK-1 while pause=0; holds while pause=1.
  - tick=1 on the cycle the count wraps to 0.
- Edge detect: care_q and heal_q are registered copies. A rise is in=1 && q=0. A held level produces exactly one event.
- Per channel, state OK / CRITICAL / EMPTY:
  - Decay counter increments on tick. When it reaches DECAY_i-1 with a tick, it clears and issues a decay.
  - Care rise: level+1, saturating at LVL_MAX. Decay: level-1, saturating at 0.
  - Care rise and decay on the same cycle: level unchanged, decay counter still clears.
  - Updates take effect at the clock edge where the event is seen; visible the following cycle (1-cycle latency).
  - State is derived from the level: lvl>CRIT_LVL → OK; 0<lvl≤CRIT_LVL → CRITICAL; lvl==0 → EMPTY. crit=1 in CRITICAL or EMPTY.
- Health:
  - Penalty accumulator advances on tick: +2 if any channel is EMPTY, else +1 if any channel is CRITICAL, else it clears to 0.
  - When the accumulator is ≥ HEALTH_PENALTY_TICKS: health-1 and accumulator clears. Never accumulate beyond the threshold.
  - Heal rise: health+1, saturating at LVL_MAX.
  - Heal and penalty on the same cycle: health unchanged, accumulator clears.
- Top FSM, states ALIVE / DEAD:
  - ALIVE → DEAD on the edge where health would become 0.
  - DEAD: dead=1; all need_lvl=0; health_lvl=0; crit=all 1.
  - In DEAD, care, heal and pause are ignored, the prescaler still runs, and tick is still output.
  - Only rst leaves DEAD.
- Widths: counters sized with $clog2 of their limits. All level arithmetic is done in LVL_W+1 bits, then clamped, so there is no wrap-around.

Decomposition:
- Shared package/include holds:
  - state encodings: NEED_OK=2'd0, NEED_CRIT=2'd1, NEED_EMPTY=2'd2; ALIVE=1'b0, DEAD=1'b1
  - the saturating inc/dec function
  - the DECAY_VEC field-extract macro
- One sub-module, need_channel, generated NUM_NEEDS times. It contains the edge detect, decay counter, saturating level and state/crit output. Parameters: LVL_W, LVL_MAX, CRIT_LVL, DECAY; inputs: tick, care, kill.
- The top level holds the prescaler, health accumulator, health meter and ALIVE/DEAD FSM.

Test Plan:
Bench overrides: CLK_PER_TICK=4, DECAY_VEC=all 8'd2, LVL_MAX=5, CRIT_LVL=2, HEALTH_PENALTY_TICKS=4.
1. Release rst → all need_lvl=5, health=5, dead=0. tick every 4 clk. After 2 ticks, all need_lvl=4.
2. care[0] held high 20 clk from lvl 4 → need_lvl[0]=5 exactly once. Further care at 5 stays 5.
3. care[1] rise on the same cycle as the channel-1 decay → need_lvl[1] unchanged; the next decay occurs 2 ticks later.
4. No care, decay to lvl 2 → crit=4'hF; health drops to 4 after 4 ticks. Once any lvl=0, health drops every 2 ticks.
5. Continue until health=0 → dead=1, all levels 0. care/heal pulses produce no change. Assert rst mid-tick → outputs at reset values without a clock edge.
6. heal rise at health 5 → stays 5. pause=1 for 40 clk → no tick, levels frozen; prescaler resumes from its held count.
